// File: rtl/grostl_add_round_const.sv
// Groestl AddRoundConstant pipeline stage.
//
// Takes one 512-bit state beat per cycle, XORs in the P or Q round constant
// and presents the result one cycle later to the SubBytes stage. A small FSM
// tracks which round is expected next. It also latches whether the running
// permutation is P or Q. Protocol violations set a sticky err flag.
//
// Ports:
//   clk        - clock; all state updates on its rising edge
//   reset      - asynchronous, active-high reset
//   in_valid   - upstream beat present
//   in_ready   - beat accepted this cycle when in_valid is also high
//   in_first   - beat is round 0 of a new permutation
//   in_is_q    - on a first beat: 1 selects Q constants, 0 selects P
//   din        - state in; byte k is row (k mod 8), column (k div 8)
//   out_valid  - dout holds a valid beat
//   out_ready  - downstream accepts the beat
//   dout       - state after AddRoundConstant, same byte order as din
//   out_round  - round index of the beat on dout
//   out_last   - beat on dout is round NUM_ROUNDS-1
//   err        - sticky protocol error (stray beat or aborted permutation)
module grostl_add_round_const #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_is_q,
  input  logic [0:63][7:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:63][7:0] dout,
  output logic [3:0]       out_round,
  output logic             out_last,
  output logic             err
);

  localparam logic [3:0] LastRnd = 4'(NUM_ROUNDS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             q_q, q_d;
  logic             out_valid_q, out_valid_d;
  logic [0:63][7:0] dout_q, dout_d;
  logic [3:0]       out_round_q, out_round_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic             accept;
  logic             beat_out;
  logic [3:0]       beat_rnd;
  logic             beat_q;

  // Column j contributes (j << 4) ^ r to row 0 (P) or row 7 (Q); Q also
  // inverts every byte.
  function automatic logic [0:63][7:0] add_rc(input logic [0:63][7:0] s,
                                              input logic [3:0]       r,
                                              input logic             is_q);
    logic [0:63][7:0] res;
    logic [7:0]       c;
    logic [5:0]       idx;
    res = s;
    if (is_q) begin
      for (int unsigned k = 0; k < 64; k++) begin
        res[k] = res[k] ^ 8'hFF;
      end
    end
    for (int unsigned j = 0; j < 8; j++) begin
      c   = {4'(j), 4'h0} ^ {4'h0, r};
      idx = is_q ? 6'(8 * j + 7) : 6'(8 * j);
      res[idx] = res[idx] ^ c;
    end
    return res;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    q_d      = q_q;
    err_d    = err_q;
    beat_out = 1'b0;
    beat_rnd = 4'h0;
    beat_q   = q_q;
    if (accept) begin
      if (in_first) begin
        // A new permutation always restarts; if one was running it is lost.
        if (state_q == StRun) begin
          err_d = 1'b1;
        end
        beat_out = 1'b1;
        beat_rnd = 4'h0;
        beat_q   = in_is_q;
        q_d      = in_is_q;
        rnd_d    = 4'h1;
        state_d  = StRun;
      end else if (state_q == StRun) begin
        beat_out = 1'b1;
        beat_rnd = rnd_q;
        beat_q   = q_q;
        if (rnd_q == LastRnd) begin
          rnd_d   = 4'h0;
          state_d = StIdle;
        end else begin
          rnd_d = rnd_q + 4'h1;
        end
      end else begin
        // Continuation beat with no permutation open: swallow it.
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    if (beat_out) begin
      out_valid_d = 1'b1;
      dout_d      = add_rc(din, beat_rnd, beat_q);
      out_round_d = beat_rnd;
      out_last_d  = (beat_rnd == LastRnd);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rnd_q       <= 4'h0;
      q_q         <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_round_q <= 4'h0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: doc/grostl_add_round_const.md
GROSTL_ADD_ROUND_CONST -- requirements
Module: grostl_add_round_const

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the number of rounds per P or Q permutation (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an upstream state beat is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 The block SHALL have port in_first, input, 1 bit: the beat is round 0 of a new permutation.
REQ-007 The block SHALL have port in_is_q, input, 1 bit: on a first beat, selects Q (1) or P (0) constants.
REQ-008 The block SHALL have port din, input, [0:63][7:0]: the 512-bit state; byte k = row (k mod 8), column (k div 8).
REQ-009 The block SHALL have port out_valid, output, 1 bit: dout holds a valid beat for the downstream SubBytes stage.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-011 The block SHALL have port dout, output, [0:63][7:0]: the state after AddRoundConstant, same byte order as din.
REQ-012 The block SHALL have port out_round, output, 4 bits: round index of the beat on dout.
REQ-013 The block SHALL have port out_last, output, 1 bit: the dout beat is round NUM_ROUNDS-1.
REQ-014 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL equal (!out_valid || out_ready).
REQ-016 Latency SHALL be one cycle: an accepted beat appears on dout/out_valid at the next edge; full throughput of one beat per cycle SHALL be sustained when out_ready=1.
REQ-017 While out_valid=1 and out_ready=0, dout, out_round, out_last and out_valid SHALL hold unchanged.
REQ-018 The FSM SHALL have states IDLE (no permutation active) and RUN (permutation active), with a round counter rnd holding the next expected round and a latched mode bit q.
REQ-019 Accepted beat with in_first=1 (any state) SHALL use round 0, latch q=in_is_q, set rnd=1 and move to RUN.
REQ-020 Accepted beat with in_first=1 in RUN SHALL additionally set err (aborted permutation).
REQ-021 Accepted beat with in_first=0 in RUN SHALL use round rnd and increment rnd; if rnd=NUM_ROUNDS-1 the FSM SHALL return to IDLE.
REQ-022 Accepted beat with in_first=0 in IDLE SHALL be consumed, SHALL NOT produce an output beat, and SHALL set err.
REQ-023 P round r: dout[8j] = din[8j] ^ {j[3:0],4'h0} ^ r for columns j=0..7; all other bytes pass through.
REQ-024 Q round r: every byte SHALL be XORed with 8'hFF, and additionally dout[8j+7] ^= {j[3:0],4'h0} ^ r (row 7 becomes ~(j<<4 ^ r) ^ din).
REQ-025 Constant arithmetic SHALL be 8-bit XOR only; r is zero-extended from 4 bits.
REQ-026 out_last SHALL be 1 exactly when out_round = NUM_ROUNDS-1.
REQ-027 err SHALL remain 1 until reset.

Reset
REQ-028 On reset assertion, asynchronously: out_valid=0, dout=0, out_round=0, out_last=0, err=0, FSM=IDLE, rnd=0, q=0.
REQ-029 in_ready SHALL be 1 during and after reset (out_valid=0).
REQ-030 Reset asserted mid-permutation SHALL discard the in-flight beat and partial round count; next in_first=0 beat SHALL set err.

Verification
REQ-031 P, all-zero din, in_first=1, in_is_q=0 -> next cycle out_valid=1, out_round=0, dout[0]=00, dout[8]=10, dout[56]=70, all other bytes 00.
REQ-032 Q, all-zero din, in_first=1, in_is_q=1 -> dout[7]=FF, dout[15]=EF, dout[63]=8F, all other bytes FF.
REQ-033 P, 10 back-to-back zero beats, out_ready=1 -> round-3 beat dout[0]=03, dout[8]=13; round-9 beat out_last=1; FSM IDLE afterwards; err=0.
REQ-034 out_ready=0 for 5 cycles with out_valid=1 -> dout stable, in_ready=0, no beats lost; after release rounds continue contiguous.
REQ-035 in_first=0 beat in IDLE -> no output beat, err=1; in_first=1 during round 4 -> err=1, output round restarts at 0.
REQ-036 reset pulsed during round 5 -> outputs zero immediately (asynchronously), in_ready=1, err=0.
